// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment output scanner.
// Holds the scan state enum, digit sizing and the hex-to-segment table.
package seg7_pkg;

   typedef enum logic {
      SHOW,
      BLANK
   } state_e;

   localparam int NUM_DIGITS = 4;
   localparam int IDX_W      = 2;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a}; entry [n] is hex digit n.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46,
      7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19,
      7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
// Ports: nib_i (hex nibble), seg_o ({g,f,e,d,c,b,a}, active-low).
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_output_scanner.sv
// Latches the CPU output value and scans it as 4 hex digits with an
// inter-digit blank cycle; drives LEDs with the PC low byte.
// Ports: clk, reset (sync, active-high), data_in/data_valid (value
// capture), pc_in (LED source), freeze (hold value and LEDs),
// seg_n/dp_n/an_n (active-low display), led, shown_value (latched value).
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg7_output_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int NUM_DIGITS_P = NUM_DIGITS
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        data_valid,
   input  logic [7:0]  pc_in,
   input  logic        freeze,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic [3:0]  an_n,
   output logic [7:0]  led,
   output logic [15:0] shown_value
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [15:0]      value_q, value_d;
   logic [7:0]       led_q, led_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       nib;
   logic [6:0]       dec;
   logic             lz_blank;

   hex_to_seg7 u_dec (
      .nib_i (nib),
      .seg_o (dec)
   );

   // Nibble is taken from next-cycle value and index so a capture
   // shows on the lit digit at the same edge.
   assign nib = value_d[{idx_d, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic [IDX_W-1:0] msd;

   always_comb begin
      msd = '0;
      if (value_d[15:12] != 4'h0)     msd = 2'd3;
      else if (value_d[11:8] != 4'h0) msd = 2'd2;
      else if (value_d[7:4] != 4'h0)  msd = 2'd1;
      lz_blank = (idx_d > msd);
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      led_d   = led_q;
      an_d    = 4'b1111;
      seg_d   = SEG_BLANK;
      dp_d    = 1'b1;

      if (data_valid && !freeze) value_d = data_in;
      if (!freeze)               led_d   = pc_in;

      unique case (state_q)
         BLANK: begin
            state_d = SHOW;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
         end
         SHOW: begin
            if (cnt_q == CNT_LAST) begin
               state_d = BLANK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = BLANK;
      endcase

      if (state_d == SHOW) begin
         an_d  = ~(4'b0001 << idx_d);
         seg_d = lz_blank ? SEG_BLANK : dec;
         dp_d  = !((idx_d == 2'd0) && freeze);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BLANK;
         idx_q   <= 2'd3;
         cnt_q   <= '0;
         value_q <= '0;
         led_q   <= '0;
         an_q    <= 4'b1111;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         led_q   <= led_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an_n        = an_q;
   assign seg_n       = seg_q;
   assign dp_n        = dp_q;
   assign led         = led_q;
   assign shown_value = value_q;

endmodule

// File: tb/tb_seg7_output_scanner.sv
// Scoreboard bench for seg7_output_scanner with REFRESH_DIV=4.
// Expected outputs are queued per driven cycle and compared after the edge.
module tb_seg7_output_scanner;

   localparam int RDIV  = 4;
   localparam int SLOT  = RDIV + 1;
   localparam int FRAME = 4 * SLOT;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] data_in;
   logic        data_valid;
   logic [7:0]  pc_in;
   logic        freeze;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;
   logic [7:0]  led;
   logic [15:0] shown_value;

   seg7_output_scanner #(.REFRESH_DIV(RDIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .pc_in       (pc_in),
      .freeze      (freeze),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .led         (led),
      .shown_value (shown_value)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      logic        dp;
      logic [7:0]  led;
      logic [15:0] val;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          k      = 0;
   logic [15:0] m_val  = '0;
   logic [7:0]  m_led  = '0;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic int msd(input logic [15:0] v);
      for (int i = 3; i > 0; i--)
         if (v[4*i +: 4] != 4'h0) return i;
      return 0;
   endfunction

   function automatic bit lit(input int kk);
      return (kk > 0) && (((kk - 1) % SLOT) != RDIV);
   endfunction

   function automatic int digit(input int kk);
      return ((kk - 1) % FRAME) / SLOT;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic fz,
                       input logic [15:0] d, input logic [7:0] pc);
      exp_t e;
      exp_t o;
      int   dg;
      reset      = rst;
      data_valid = v;
      freeze     = fz;
      data_in    = d;
      pc_in      = pc;
      if (rst) begin
         m_val = '0;
         m_led = '0;
         k     = 0;
      end else begin
         if (v && !fz) m_val = d;
         if (!fz)      m_led = pc;
         k++;
      end
      e.an  = 4'b1111;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.led = m_led;
      e.val = m_val;
      if (lit(k)) begin
         dg    = digit(k);
         e.an  = ~(4'b0001 << dg);
         e.seg = hex7(m_val[4*dg +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
         if (dg > msd(m_val)) e.seg = 7'h7F;
`endif
         e.dp  = !(dg == 0 && fz);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check("an_n",  32'(an_n),        32'(o.an));
      check("seg_n", 32'(seg_n),       32'(o.seg));
      check("dp_n",  32'(dp_n),        32'(o.dp));
      check("led",   32'(led),         32'(o.led));
      check("value", 32'(shown_value), 32'(o.val));
   endtask

   task automatic idle(input int n, input logic fz, input logic [7:0] pc);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, fz, 16'h0000, pc);
   endtask

   initial begin
      step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      step(1'b1, 1'b1, 1'b0, 16'hBEEF, 8'hAA);
      idle(2 * FRAME + 2, 1'b0, 8'h00);

      step(1'b0, 1'b1, 1'b0, 16'h6303, 8'h00);
      idle(FRAME, 1'b0, 8'h00);

      step(1'b0, 1'b1, 1'b1, 16'hFC1C, 8'h22);
      idle(FRAME, 1'b1, 8'h33);
      step(1'b0, 1'b1, 1'b0, 16'hFC1C, 8'h15);
      idle(FRAME, 1'b0, 8'h15);
      idle(8, 1'b1, 8'h1B);

      for (int i = 0; i < FRAME && !(lit(k) && digit(k) == 2); i++)
         idle(1, 1'b0, 8'h15);
      check("reach_d2", 32'(an_n), 32'(4'b1011));
      step(1'b1, 1'b1, 1'b0, 16'h9999, 8'h77);
      idle(FRAME, 1'b0, 8'h01);

      step(1'b0, 1'b1, 1'b0, 16'h0004, 8'h02);
      idle(FRAME, 1'b0, 8'h02);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 8'h03);
      idle(FRAME, 1'b0, 8'h03);
      step(1'b0, 1'b1, 1'b0, 16'h0A50, 8'h04);
      idle(FRAME, 1'b0, 8'h04);

      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) == 0), 16'($urandom),
              8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
